// File: rtl/lfsr_byte_harvester_if.sv
// rtl/lfsr_byte_harvester_if.sv - read-side byte stream of the LFSR byte harvester
interface lfsr_byte_harvester_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          RD_VALID;
    logic          RD_READY;
    logic [7:0]    RD_DATA;
    logic [LW-1:0] LEVEL;

    // Harvester side: presents the FIFO head and occupancy, accepts pops.
    modport master (
        output RD_VALID,
        output RD_DATA,
        output LEVEL,
        input  RD_READY
    );

    // Bus glue side: observes the FIFO and issues pops.
    modport slave (
        input  RD_VALID,
        input  RD_DATA,
        input  LEVEL,
        output RD_READY
    );
endinterface

// File: rtl/lfsr_byte_harvester.sv
// rtl/lfsr_byte_harvester.sv - drives an XNOR LFSR, packs its output bits into bytes and buffers them
module lfsr_byte_harvester #(
    parameter int                NUM_BITS  = 8,
    parameter int                DEPTH     = 4,
    parameter logic [NUM_BITS:1] INIT_SEED = '0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RUN_i,
    input  logic                 SEED_REQ_i,
    input  logic [NUM_BITS:1]    SEED_IN_i,
    input  logic [NUM_BITS:1]    LFSR_Q_i,
    output logic                 LFSR_E_o,
    output logic                 LFSR_RESET_o,
    output logic [NUM_BITS:1]    LFSR_SEED_o,
    output logic                 LOCKUP_o,
    lfsr_byte_harvester_if.master rd
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GEN    = 2'd2,
        ST_STUCK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_BITS:1] seed_q, seed_d;
    logic              lockup_q, lockup_d;
    // shift_q remembers that the LFSR shifted last cycle, so LFSR_Q[1] now holds a fresh bit.
    logic              shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [7:0]        mem_q [DEPTH];

    logic              all_ones;
    logic              completing;
    logic              push_now;
    logic              stall;
    logic              lfsr_e;
    logic              lfsr_load;
    logic              flush;
    logic              capture;
    logic              push;
    logic              pop;
    logic              rd_valid;
    logic [7:0]        push_data;

    // XNOR feedback locks up in the all-ones state, so that state is never shifted.
    assign all_ones   = &LFSR_Q_i;

    // Only the bit that finishes a byte can be held back; partial bytes always progress.
    assign completing = (({1'b0, bitcnt_q} + {3'b000, shift_q}) == 4'd7);
    assign push_now   = shift_q & (bitcnt_q == 3'd7);
    // Pops are ignored here on purpose, so a push can never land on a full FIFO.
    assign stall      = completing &
                        (({1'b0, level_q} + {{LW{1'b0}}, push_now}) >= (LW+1)'(DEPTH));

    // Control FSM: sequencing of seed load, settle, generation and lock-up.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        lockup_d  = lockup_q;
        lfsr_e    = 1'b0;
        lfsr_load = 1'b0;
        case (state_q)
            ST_LOAD: begin
                lfsr_load = 1'b1;
                lockup_d  = 1'b0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (all_ones) begin
                    lockup_d = 1'b1;
                    state_d  = ST_STUCK;
                end else begin
                    state_d  = ST_GEN;
                end
            end
            ST_GEN: begin
                if (all_ones) begin
                    lockup_d = 1'b1;
                    state_d  = ST_STUCK;
                end else begin
                    lfsr_e   = RUN_i & ~stall;
                end
            end
            ST_STUCK: begin
                state_d = ST_STUCK;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        // A reseed request wins over everything, including a LOAD already in progress.
        if (SEED_REQ_i) begin
            seed_d  = SEED_IN_i;
            state_d = ST_LOAD;
        end
    end

    assign flush     = (state_q == ST_LOAD);
    assign capture   = shift_q & ~flush;
    // The final bit is taken straight from the LFSR so the byte is pushed in its capture cycle.
    assign push_data = {shreg_q[7:1], LFSR_Q_i[1]};
    assign push      = capture & (bitcnt_q == 3'd7) & ~SEED_REQ_i;
    assign rd_valid  = (level_q != '0) & ~RESET;
    assign pop       = rd_valid & rd.RD_READY & ~flush;

    // Bit packing and FIFO pointer/occupancy next-state.
    always_comb begin
        shift_d  = lfsr_e & ~flush;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        if (flush) begin
            bitcnt_d = 3'd0;
            shreg_d  = 8'h00;
            wptr_d   = '0;
            rptr_d   = '0;
            level_d  = '0;
        end else begin
            if (capture) begin
                shreg_d[3'd7 - bitcnt_q] = LFSR_Q_i[1];
                bitcnt_d                 = bitcnt_q + 3'd1;
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_LOAD;
            seed_q   <= INIT_SEED;
            lockup_q <= 1'b0;
            shift_q  <= 1'b0;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            lockup_q <= lockup_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Enable and read-side status are forced quiet while RESET is held.
    assign LFSR_E_o     = lfsr_e & ~RESET;
    assign LFSR_RESET_o = lfsr_load;
    assign LFSR_SEED_o  = seed_q;
    assign LOCKUP_o     = lockup_q;
    assign rd.RD_VALID  = rd_valid;
    assign rd.RD_DATA   = mem_q[rptr_q];
    assign rd.LEVEL     = RESET ? '0 : level_q;
endmodule

// File: tb/tb_lfsr_byte_harvester.sv
// tb/tb_lfsr_byte_harvester.sv - self-checking bench for lfsr_byte_harvester
module tb_lfsr_byte_harvester;
    localparam int         NUM_BITS  = 8;
    localparam int         DEPTH     = 4;
    localparam logic [8:1] INIT_SEED = 8'h00;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       run;
    logic       seed_req;
    logic [8:1] seed_in;
    logic [8:1] lfsr_q;
    logic       lfsr_e;
    logic       lfsr_rst;
    logic [8:1] lfsr_seed;
    logic       lockup;

    int         checks   = 0;
    int         failures = 0;
    int         e_cnt    = 0;
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];

    lfsr_byte_harvester_if #(.DEPTH(DEPTH)) rd_if ();

    lfsr_byte_harvester #(
        .NUM_BITS (NUM_BITS),
        .DEPTH    (DEPTH),
        .INIT_SEED(INIT_SEED)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RUN_i       (run),
        .SEED_REQ_i  (seed_req),
        .SEED_IN_i   (seed_in),
        .LFSR_Q_i    (lfsr_q),
        .LFSR_E_o    (lfsr_e),
        .LFSR_RESET_o(lfsr_rst),
        .LFSR_SEED_o (lfsr_seed),
        .LOCKUP_o    (lockup),
        .rd          (rd_if)
    );

    always #5 CLK = ~CLK;

    // The team's 8-bit XNOR LFSR: taps 8,6,5,4, new bit enters at index 1, seed loads only when idle.
    always_ff @(posedge CLK) begin
        if (lfsr_e) begin
            lfsr_q <= {lfsr_q[7:1], ~(lfsr_q[8] ^ lfsr_q[6] ^ lfsr_q[5] ^ lfsr_q[4])};
        end else if (lfsr_rst) begin
            lfsr_q <= lfsr_seed;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of popped bytes plus per-cycle FIFO sanity.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (rd_if.RD_VALID && rd_if.RD_READY) got_q.push_back(rd_if.RD_DATA);
            if (lfsr_e) e_cnt++;
            chk("valid_tracks_level", 32'(rd_if.RD_VALID), 32'(rd_if.LEVEL != 0));
            chk("level_within_depth", 32'(rd_if.LEVEL <= DEPTH), 32'd1);
        end
    end

    // Expected bytes from the LFSR recurrence s[n] = ~(s[n-8]^s[n-6]^s[n-5]^s[n-4]), packed MSB first.
    task automatic build_ref(input logic [7:0] seed, input int nbytes);
        bit         seq[$];
        logic [7:0] b;
        ref_q.delete();
        for (int k = 7; k >= 0; k--) seq.push_back(seed[k]);
        for (int n = 8; n < 8 + 8 * nbytes; n++)
            seq.push_back(~(seq[n-8] ^ seq[n-6] ^ seq[n-5] ^ seq[n-4]));
        for (int j = 0; j < nbytes; j++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], seq[8 + 8*j + i]};
            ref_q.push_back(b);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic reseed(input logic [7:0] s);
        seed_in  = s;
        seed_req = 1'b1;
        tick(1);
        seed_req = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_count"}, 32'(got_q.size() >= n), 32'd1);
        for (int i = 0; i < n && i < got_q.size(); i++) chk(tag, 32'(got_q[i]), 32'(ref_q[i]));
    endtask

    initial begin
        logic [7:0] s;
        int         k;

        // Reset state
        RESET = 1'b1; run = 1'b0; seed_req = 1'b0; seed_in = 8'h00; rd_if.RD_READY = 1'b0;
        tick(3);
        chk("rst_lfsr_e", 32'(lfsr_e), 32'd0);
        chk("rst_rd_valid", 32'(rd_if.RD_VALID), 32'd0);
        chk("rst_level", 32'(rd_if.LEVEL), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);

        // First byte latency from INIT_SEED
        build_ref(INIT_SEED, 16);
        RESET = 1'b0; run = 1'b1;
        chk("load_strobe", 32'(lfsr_rst), 32'd1);
        chk("load_seed", 32'(lfsr_seed), 32'(INIT_SEED));
        chk("load_no_shift", 32'(lfsr_e), 32'd0);
        tick(1);
        chk("settle_no_shift", 32'(lfsr_e), 32'd0);
        chk("settle_strobe_low", 32'(lfsr_rst), 32'd0);
        tick(1);
        chk("gen_shift", 32'(lfsr_e), 32'd1);
        tick(8);
        chk("valid_not_yet", 32'(rd_if.RD_VALID), 32'd0);
        tick(1);
        chk("valid_at_11", 32'(rd_if.RD_VALID), 32'd1);
        chk("first_byte", 32'(rd_if.RD_DATA), 32'(ref_q[0]));
        got_q.delete();
        rd_if.RD_READY = 1'b1;
        expect_stream("free_run", 16, 400);

        // Backpressure: FIFO fills to DEPTH, then one pop buys exactly one byte
        rd_if.RD_READY = 1'b0;
        reseed(8'h00);
        got_q.delete(); e_cnt = 0;
        build_ref(8'h00, 12);
        tick(70);
        chk("full_level", 32'(rd_if.LEVEL), 32'(DEPTH));
        chk("full_shift_count", 32'(e_cnt), 32'd39);
        chk("full_head", 32'(rd_if.RD_DATA), 32'(ref_q[0]));
        rd_if.RD_READY = 1'b1;
        tick(1);
        rd_if.RD_READY = 1'b0;
        tick(20);
        chk("refill_level", 32'(rd_if.LEVEL), 32'(DEPTH));
        chk("refill_shift_count", 32'(e_cnt), 32'd47);
        rd_if.RD_READY = 1'b1;
        expect_stream("backpressure", 12, 400);

        // Lock-up seed, then recovery
        rd_if.RD_READY = 1'b0;
        reseed(8'hFF);
        e_cnt = 0;
        chk("ff_strobe", 32'(lfsr_rst), 32'd1);
        chk("ff_seed", 32'(lfsr_seed), 32'hFF);
        tick(1);
        chk("ff_strobe_once", 32'(lfsr_rst), 32'd0);
        tick(1);
        chk("lockup_set", 32'(lockup), 32'd1);
        tick(20);
        chk("stuck_no_shift", 32'(e_cnt), 32'd0);
        chk("stuck_empty", 32'(rd_if.RD_VALID), 32'd0);
        chk("lockup_sticky", 32'(lockup), 32'd1);
        rd_if.RD_READY = 1'b1;
        got_q.delete();
        build_ref(8'h00, 4);
        reseed(8'h00);
        tick(1);
        chk("lockup_cleared", 32'(lockup), 32'd0);
        expect_stream("after_lockup", 4, 200);

        // Reseed mid-byte with three bytes queued
        rd_if.RD_READY = 1'b0;
        reseed(8'h00);
        k = 0;
        while (rd_if.LEVEL != 3 && k < 100) begin
            tick(1);
            k++;
        end
        tick(4);
        chk("pre_reseed_level", 32'(rd_if.LEVEL), 32'd3);
        s = 8'($urandom_range(0, 254));
        reseed(s);
        got_q.delete();
        build_ref(s, 6);
        tick(1);
        chk("flushed_level", 32'(rd_if.LEVEL), 32'd0);
        chk("flushed_valid", 32'(rd_if.RD_VALID), 32'd0);
        rd_if.RD_READY = 1'b1;
        expect_stream("reseed_stream", 6, 300);

        // RUN toggling every 3 cycles with random pops
        s = 8'($urandom_range(0, 254));
        reseed(s);
        got_q.delete();
        build_ref(s, 200);
        k = 0;
        while (got_q.size() < 200 && k < 20000) begin
            run            = ((k / 3) % 2) == 0;
            rd_if.RD_READY = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        run = 1'b1;
        expect_stream("toggled_stream", 200, 10);

        // RESET while data is queued and a bit is in flight
        rd_if.RD_READY = 1'b0;
        s = 8'($urandom_range(0, 254));
        reseed(s);
        k = 0;
        while (!(rd_if.RD_VALID && lfsr_e) && k < 100) begin
            tick(1);
            k++;
        end
        tick(1);
        RESET = 1'b1;
        tick(1);
        chk("midrst_valid", 32'(rd_if.RD_VALID), 32'd0);
        chk("midrst_level", 32'(rd_if.LEVEL), 32'd0);
        chk("midrst_lfsr_e", 32'(lfsr_e), 32'd0);
        chk("midrst_load", 32'(lfsr_rst), 32'd1);
        chk("midrst_seed", 32'(lfsr_seed), 32'(INIT_SEED));
        RESET = 1'b0;
        got_q.delete();
        build_ref(INIT_SEED, 3);
        rd_if.RD_READY = 1'b1;
        expect_stream("after_reset", 3, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
